// File: rtl/maquina_primaria_if.sv
// Processor/bus/memory signal bundle for the MESI cache controller.
// The slave view belongs to the controller, the master view to its environment.
interface maquina_primaria_if;
    logic       CpuRead;
    logic       CpuWrite;
    logic       Hit;
    logic [1:0] LineState;
    logic       SharedIn;
    logic       BusGrant;
    logic       MemReady;
    logic       BusReq;
    logic       BusReadMiss;
    logic       BusWriteMiss;
    logic       BusInvalid;
    logic       WriteBack;
    logic       MemoryAccess;
    logic [1:0] NewState;
    logic       Done;
    logic       CpuStall;

    modport slave (
        input  CpuRead, CpuWrite, Hit, LineState,
        input  SharedIn, BusGrant, MemReady,
        output BusReq, BusReadMiss, BusWriteMiss,
        output BusInvalid, WriteBack, MemoryAccess,
        output NewState, Done, CpuStall
    );

    modport master (
        output CpuRead, CpuWrite, Hit, LineState,
        output SharedIn, BusGrant, MemReady,
        input  BusReq, BusReadMiss, BusWriteMiss,
        input  BusInvalid, WriteBack, MemoryAccess,
        input  NewState, Done, CpuStall
    );
endinterface

// File: rtl/maquina_primaria.sv
// MESI cache line controller: hits, S->M upgrades, misses with victim
// write-back and line fetch. All outputs are registered with the state.
module maquina_primaria (
    input logic                Clock,
    input logic                ResetN,
    maquina_primaria_if.slave  bus
);
    localparam logic [1:0] ST_E = 2'b00;
    localparam logic [1:0] ST_I = 2'b01;
    localparam logic [1:0] ST_S = 2'b10;
    localparam logic [1:0] ST_M = 2'b11;

    typedef enum logic [2:0] {
        IDLE, ARB, WB, FETCH, INV, DONE
    } state_t;

    state_t     state;
    logic       opWrite;
    logic       opHit;
    logic [1:0] opState;
    logic       reqHit;
    logic       reqFast;

    // A tag match on an Invalid line is still a miss.
    assign reqHit  = bus.Hit && (bus.LineState != ST_I);
    // Every hit completes locally except a write to a Shared line.
    assign reqFast = reqHit &&
                     (!bus.CpuWrite || bus.LineState != ST_S);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state            <= IDLE;
            opWrite          <= 1'b0;
            opHit            <= 1'b0;
            opState          <= ST_I;
            bus.BusReq       <= 1'b0;
            bus.BusReadMiss  <= 1'b0;
            bus.BusWriteMiss <= 1'b0;
            bus.BusInvalid   <= 1'b0;
            bus.WriteBack    <= 1'b0;
            bus.MemoryAccess <= 1'b0;
            bus.NewState     <= ST_I;
            bus.Done         <= 1'b0;
            bus.CpuStall     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.CpuRead || bus.CpuWrite) begin
                        opWrite      <= bus.CpuWrite;
                        opHit        <= reqHit;
                        opState      <= bus.LineState;
                        bus.CpuStall <= 1'b1;
                        if (reqFast) begin
                            state        <= DONE;
                            bus.Done     <= 1'b1;
                            bus.NewState <= bus.CpuWrite ?
                                            ST_M : bus.LineState;
                        end else begin
                            state      <= ARB;
                            bus.BusReq <= 1'b1;
                        end
                    end
                end
                ARB: begin
                    if (bus.BusGrant) begin
                        // Only S-upgrades reach ARB with a hit.
                        if (opHit) begin
                            state          <= INV;
                            bus.BusInvalid <= 1'b1;
                        end else if (opState == ST_M) begin
                            state            <= WB;
                            bus.WriteBack    <= 1'b1;
                            bus.MemoryAccess <= 1'b1;
                        end else begin
                            state            <= FETCH;
                            bus.MemoryAccess <= 1'b1;
                            bus.BusReadMiss  <= !opWrite;
                            bus.BusWriteMiss <= opWrite;
                        end
                    end
                end
                WB: begin
                    if (bus.MemReady) begin
                        state            <= FETCH;
                        bus.WriteBack    <= 1'b0;
                        bus.BusReadMiss  <= !opWrite;
                        bus.BusWriteMiss <= opWrite;
                    end
                end
                FETCH: begin
                    if (bus.MemReady) begin
                        state            <= DONE;
                        bus.MemoryAccess <= 1'b0;
                        bus.BusReadMiss  <= 1'b0;
                        bus.BusWriteMiss <= 1'b0;
                        bus.BusReq       <= 1'b0;
                        bus.Done         <= 1'b1;
                        if (opWrite)
                            bus.NewState <= ST_M;
                        else
                            bus.NewState <= bus.SharedIn ?
                                            ST_S : ST_E;
                    end
                end
                INV: begin
                    state          <= DONE;
                    bus.BusInvalid <= 1'b0;
                    bus.BusReq     <= 1'b0;
                    bus.Done       <= 1'b1;
                    bus.NewState   <= ST_M;
                end
                DONE: begin
                    state        <= IDLE;
                    bus.Done     <= 1'b0;
                    bus.CpuStall <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_maquina_primaria.sv
// Directed-vector bench for the MESI controller.
// Inputs change and outputs are sampled on the falling edge.
module tb_maquina_primaria;
    logic Clock;
    logic ResetN;
    int   nTests;
    int   nFail;

    maquina_primaria_if bus ();

    maquina_primaria dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clock);
    endtask

    task automatic clearIn();
        bus.CpuRead   = 1'b0;
        bus.CpuWrite  = 1'b0;
        bus.Hit       = 1'b0;
        bus.LineState = 2'b01;
        bus.SharedIn  = 1'b0;
        bus.BusGrant  = 1'b0;
        bus.MemReady  = 1'b0;
    endtask

    task automatic request(input logic rd, input logic wr,
                           input logic h, input logic [1:0] ls);
        bus.CpuRead   = rd;
        bus.CpuWrite  = wr;
        bus.Hit       = h;
        bus.LineState = ls;
    endtask

    function automatic logic [7:0] busAct();
        return {2'b00, bus.BusReq, bus.BusReadMiss,
                bus.BusWriteMiss, bus.BusInvalid,
                bus.WriteBack, bus.MemoryAccess};
    endfunction

    initial begin
        nTests = 0;
        nFail  = 0;
        clearIn();
        ResetN = 1'b0;
        #12;
        chk("rst_outs", busAct(), 8'h00);
        chk("rst_done", {7'd0, bus.Done}, 8'd0);
        chk("rst_stall", {7'd0, bus.CpuStall}, 8'd0);
        chk("rst_ns", {6'd0, bus.NewState}, 8'd1);
        step();
        ResetN = 1'b1;

        // Grant with no request must do nothing.
        bus.BusGrant = 1'b1;
        bus.MemReady = 1'b1;
        step();
        chk("idle_grant", busAct(), 8'h00);
        chk("idle_stall", {7'd0, bus.CpuStall}, 8'd0);
        clearIn();

        // Read hit on S.
        request(1, 0, 1, 2'b10);
        step();
        clearIn();
        chk("rdS_done", {7'd0, bus.Done}, 8'd1);
        chk("rdS_ns", {6'd0, bus.NewState}, 8'd2);
        chk("rdS_bus", busAct(), 8'h00);
        chk("rdS_stall", {7'd0, bus.CpuStall}, 8'd1);
        step();
        chk("rdS_done2", {7'd0, bus.Done}, 8'd0);
        chk("rdS_idle", {7'd0, bus.CpuStall}, 8'd0);
        chk("rdS_hold", {6'd0, bus.NewState}, 8'd2);

        // Write hit on S: upgrade, grant after 3 cycles.
        request(0, 1, 1, 2'b10);
        step();
        request(1, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            chk("up_arb", busAct(), 8'h20);
            chk("up_stall", {7'd0, bus.CpuStall}, 8'd1);
            step();
        end
        clearIn();
        bus.BusGrant = 1'b1;
        chk("up_arb3", busAct(), 8'h20);
        step();
        bus.BusGrant = 1'b0;
        chk("up_inv", busAct(), 8'h24);
        chk("up_inv_dn", {7'd0, bus.Done}, 8'd0);
        step();
        chk("up_done", {7'd0, bus.Done}, 8'd1);
        chk("up_bus", busAct(), 8'h00);
        chk("up_ns", {6'd0, bus.NewState}, 8'd3);
        step();

        // Read miss with Modified victim.
        request(1, 0, 0, 2'b11);
        step();
        clearIn();
        bus.LineState = 2'b00;
        bus.BusGrant  = 1'b1;
        chk("wb_arb", busAct(), 8'h20);
        step();
        bus.BusGrant = 1'b0;
        chk("wb_c1", busAct(), 8'h23);
        step();
        bus.MemReady = 1'b1;
        chk("wb_c2", busAct(), 8'h23);
        step();
        bus.MemReady = 1'b0;
        chk("fe_c1", busAct(), 8'h31);
        step();
        bus.MemReady = 1'b1;
        bus.SharedIn = 1'b1;
        chk("fe_c2", busAct(), 8'h31);
        step();
        clearIn();
        chk("wb_done", {7'd0, bus.Done}, 8'd1);
        chk("wb_bus", busAct(), 8'h00);
        chk("wb_ns", {6'd0, bus.NewState}, 8'd2);
        step();

        // Read miss on Invalid line, SharedIn low.
        request(1, 0, 1, 2'b01);
        step();
        clearIn();
        bus.BusGrant = 1'b1;
        chk("rm_arb", busAct(), 8'h20);
        step();
        bus.BusGrant = 1'b0;
        bus.MemReady = 1'b1;
        chk("rm_fetch", busAct(), 8'h31);
        step();
        clearIn();
        chk("rm_done", {7'd0, bus.Done}, 8'd1);
        chk("rm_ns", {6'd0, bus.NewState}, 8'd0);
        step();

        // Write miss.
        request(0, 1, 0, 2'b00);
        step();
        clearIn();
        bus.BusGrant = 1'b1;
        step();
        bus.BusGrant = 1'b0;
        chk("wm_fetch", busAct(), 8'h29);
        step();
        bus.MemReady = 1'b1;
        chk("wm_wait", busAct(), 8'h29);
        step();
        clearIn();
        chk("wm_done", {7'd0, bus.Done}, 8'd1);
        chk("wm_ns", {6'd0, bus.NewState}, 8'd3);
        step();

        // Read and write together on Exclusive hit.
        request(1, 1, 1, 2'b00);
        step();
        clearIn();
        chk("both_done", {7'd0, bus.Done}, 8'd1);
        chk("both_ns", {6'd0, bus.NewState}, 8'd3);
        chk("both_bus", busAct(), 8'h00);
        step();

        // Reset in the middle of FETCH.
        request(1, 0, 0, 2'b00);
        step();
        clearIn();
        bus.BusGrant = 1'b1;
        step();
        bus.BusGrant = 1'b0;
        chk("rf_fetch", busAct(), 8'h31);
        #2;
        ResetN = 1'b0;
        #1;
        chk("rf_async", busAct(), 8'h00);
        chk("rf_ns", {6'd0, bus.NewState}, 8'd1);
        chk("rf_stall", {7'd0, bus.CpuStall}, 8'd0);
        bus.MemReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rf_nodone", {7'd0, bus.Done}, 8'd0);
        end
        ResetN = 1'b1;
        clearIn();
        step();
        chk("rf_after", {7'd0, bus.Done}, 8'd0);
        chk("rf_after_bus", busAct(), 8'h00);
        request(1, 0, 1, 2'b11);
        step();
        clearIn();
        chk("rf_first", {7'd0, bus.Done}, 8'd1);
        chk("rf_first_ns", {6'd0, bus.NewState}, 8'd3);
        step();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
